// File: rtl/sram_mem_ctrl.sv
// sram_mem_ctrl: MEM-stage data-memory responder for an external 16-bit
// asynchronous SRAM. A 32-bit load or store becomes two half-word phases,
// low half first. While an access is in flight, ready is held low so the
// pipeline stays frozen.
//
// Handshake: a request (wr_en or rd_en) is taken when ready would otherwise
// be high in IDLE. The requester keeps the request stable while ready=0.
// ready returns to 1 for exactly one cycle (DONE), and the requester advances
// on that edge. A write wins when wr_en and rd_en are both set.
module sram_mem_ctrl #(
    parameter logic [31:0] ADDR_BASE   = 32'd1024,
    parameter int          SRAM_AW     = 18,
    parameter int          WAIT_CYCLES = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               wr_en,
    input  logic               rd_en,
    input  logic [31:0]        addr,
    input  logic [31:0]        wdata,
    output logic [31:0]        rdata,
    output logic               ready,
    inout  wire  [15:0]        SRAM_DQ,
    output logic [SRAM_AW-1:0] SRAM_ADDR,
    output logic               SRAM_WE_N,
    output logic               SRAM_OE_N,
    output logic               SRAM_CE_N,
    output logic               SRAM_UB_N,
    output logic               SRAM_LB_N,
    output logic [1:0]         dbg_state_o
);

    localparam int CW = (WAIT_CYCLES < 2) ? 1 : $clog2(WAIT_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(WAIT_CYCLES);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LO   = 2'd1,
        S_HI   = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic               is_wr_q, is_wr_d;
    logic [SRAM_AW-2:0] word_q, word_d;
    logic [31:0]        wdata_q, wdata_d;
    logic [31:0]        rdata_q, rdata_d;

    // Byte offset from the SRAM base; only the word-index bits are kept, so
    // addresses outside the window wrap modulo the SRAM size.
    logic [31:0] offs;
    logic        unused_offs;
    assign offs        = addr - ADDR_BASE;
    assign unused_offs = ^{offs[31:SRAM_AW+1], offs[1:0]};

    logic req;
    logic in_phase;
    logic last_cyc;
    assign req      = wr_en | rd_en;
    assign in_phase = (state_q == S_LO) || (state_q == S_HI);
    assign last_cyc = (cnt_q == CNT_LAST);

    // State and request-holding registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            is_wr_q <= 1'b0;
            word_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            is_wr_q <= is_wr_d;
            word_q  <= word_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
        end
    end

    // Next-state: phase sequencing, request capture on IDLE->LO, read capture
    // on the final cycle of each read phase.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        is_wr_d = is_wr_q;
        word_d  = word_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        unique case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                if (req) begin
                    state_d = S_LO;
                    is_wr_d = wr_en;
                    word_d  = offs[SRAM_AW:2];
                    wdata_d = wdata;
                end
            end
            S_LO: begin
                if (last_cyc) begin
                    state_d = S_HI;
                    cnt_d   = '0;
                    if (!is_wr_q) rdata_d[15:0] = SRAM_DQ;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_HI: begin
                if (last_cyc) begin
                    state_d = S_DONE;
                    cnt_d   = '0;
                    if (!is_wr_q) rdata_d[31:16] = SRAM_DQ;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // SRAM controls decoded from registered state only. WE_N rises on the
    // last phase cycle so data is held past the write strobe.
    logic        dq_oe;
    logic [15:0] dq_out;
    assign dq_oe     = in_phase && is_wr_q;
    assign dq_out    = (state_q == S_HI) ? wdata_q[31:16] : wdata_q[15:0];
    assign SRAM_DQ   = dq_oe ? dq_out : 16'bz;
    assign SRAM_ADDR = {word_q, (state_q == S_HI)};
    assign SRAM_CE_N = ~in_phase;
    assign SRAM_OE_N = ~(in_phase && !is_wr_q);
    assign SRAM_WE_N = ~(in_phase && is_wr_q && !last_cyc);
    assign SRAM_UB_N = 1'b0;
    assign SRAM_LB_N = 1'b0;

    assign ready       = (state_q == S_IDLE) ? ~req : (state_q == S_DONE);
    assign rdata       = rdata_q;
    assign dbg_state_o = state_q;

endmodule
